// File: rtl/ic74595_tsreg.sv
// Parametrised 74x595-style serial-in shift register with storage register,
// tri-state parallel output, optional inverted polarity and optional auto-latch.
module ic74595_tsreg #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned INVERT     = 0,
    parameter int unsigned AUTO_LATCH = 0
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             shift_en,
    input  logic             ser_in,
    input  logic             latch_en,
    input  logic             nsclr,
    input  logic             noe,
    output logic [WIDTH-1:0] q,
    output logic             ser_out,
    output logic             word_rdy
);

    localparam int unsigned CNT_W  = $clog2(WIDTH + 1);
    localparam bit          INV_EN = (INVERT != 0);
    localparam bit          AUTO   = (AUTO_LATCH != 0);

    logic [WIDTH-1:0] sr_q,    sr_d;
    logic [WIDTH-1:0] store_q, store_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             word_rdy_q, word_rdy_d;
    logic             auto_fire_c;
    logic [WIDTH-1:0] q_drv_c;

    // Next-state: clear beats shift; latch sees pre-edge sr; auto-latch sees post-shift sr.
    always_comb begin
        sr_d        = sr_q;
        store_d     = store_q;
        cnt_d       = cnt_q;
        auto_fire_c = 1'b0;

        if (!nsclr) begin
            sr_d  = '0;
            cnt_d = '0;
        end else if (shift_en) begin
            sr_d = {sr_q[WIDTH-2:0], ser_in};
            if (cnt_q != CNT_W'(WIDTH)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            auto_fire_c = AUTO && (cnt_q == CNT_W'(WIDTH - 1));
        end

        if (auto_fire_c) begin
            store_d = sr_d;
            cnt_d   = '0;
        end else if (latch_en) begin
            store_d = sr_q;
            cnt_d   = '0;
        end

        word_rdy_d = !AUTO && (cnt_d == CNT_W'(WIDTH));
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sr_q       <= '0;
            store_q    <= '0;
            cnt_q      <= '0;
            word_rdy_q <= 1'b0;
        end else begin
            sr_q       <= sr_d;
            store_q    <= store_d;
            cnt_q      <= cnt_d;
            word_rdy_q <= word_rdy_d;
        end
    end

    // Output driver: polarity select then combinational tri-state enable.
    assign q_drv_c  = INV_EN ? ~store_q : store_q;
    assign q        = noe ? {WIDTH{1'bz}} : q_drv_c;
    assign ser_out  = sr_q[WIDTH-1];
    assign word_rdy = word_rdy_q;

endmodule

// File: tb/tb_ic74595_tsreg.sv
// Bench for ic74595_tsreg: three instances (plain, inverted, auto-latch) share
// stimulus; released outputs are pulled up so a floating bus reads as all ones.
module tb_ic74595_tsreg;

    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    logic shift_en = 1'b0;
    logic ser_in = 1'b0;
    logic latch_en = 1'b0;
    logic nsclr = 1'b1;
    logic noe = 1'b1;

    wire [W-1:0] q0, q1, q2;
    wire so0, so1, so2, wr0, wr1, wr2;

    int total = 0;
    int bad   = 0;

    // Behavioural model state per instance: 0 plain, 1 inverted, 2 auto-latch.
    int m_sr[3];
    int m_store[3];
    int m_cnt[3];

    always #5 clk = ~clk;

    for (genvar i = 0; i < W; i++) begin : g_pu
        pullup (q0[i]);
        pullup (q1[i]);
        pullup (q2[i]);
    end

    ic74595_tsreg #(.WIDTH(W), .INVERT(0), .AUTO_LATCH(0)) dut_plain (
        .clk(clk), .nrst(nrst), .shift_en(shift_en), .ser_in(ser_in), .latch_en(latch_en),
        .nsclr(nsclr), .noe(noe), .q(q0), .ser_out(so0), .word_rdy(wr0));
    ic74595_tsreg #(.WIDTH(W), .INVERT(1), .AUTO_LATCH(0)) dut_inv (
        .clk(clk), .nrst(nrst), .shift_en(shift_en), .ser_in(ser_in), .latch_en(latch_en),
        .nsclr(nsclr), .noe(noe), .q(q1), .ser_out(so1), .word_rdy(wr1));
    ic74595_tsreg #(.WIDTH(W), .INVERT(0), .AUTO_LATCH(1)) dut_auto (
        .clk(clk), .nrst(nrst), .shift_en(shift_en), .ser_in(ser_in), .latch_en(latch_en),
        .nsclr(nsclr), .noe(noe), .q(q2), .ser_out(so2), .word_rdy(wr2));

    function automatic logic [W-1:0] q_of(input int k);
        case (k)
            0:       return q0;
            1:       return q1;
            default: return q2;
        endcase
    endfunction

    function automatic logic so_of(input int k);
        case (k)
            0:       return so0;
            1:       return so1;
            default: return so2;
        endcase
    endfunction

    function automatic logic wr_of(input int k);
        case (k)
            0:       return wr0;
            1:       return wr1;
            default: return wr2;
        endcase
    endfunction

    function automatic logic [W-1:0] exp_q(input int k);
        logic [W-1:0] s;
        s = W'(m_store[k]);
        if (noe) return {W{1'b1}};
        return (k == 1) ? ~s : s;
    endfunction

    function automatic logic exp_so(input int k);
        return ((m_sr[k] >> (W - 1)) & 1) != 0;
    endfunction

    function automatic logic exp_wr(input int k);
        return (k != 2) && (m_cnt[k] == W);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_sr[k] = 0; m_store[k] = 0; m_cnt[k] = 0;
        end
    endtask

    // One clock edge of the datasheet behaviour, written as integer arithmetic.
    task automatic model_edge(input logic sh, input logic b, input logic la, input logic cl);
        int pre;
        bit reached;
        for (int k = 0; k < 3; k++) begin
            pre     = m_sr[k];
            reached = 1'b0;
            if (!cl) begin
                m_sr[k] = 0; m_cnt[k] = 0;
            end else if (sh) begin
                m_sr[k] = ((m_sr[k] * 2) + int'(b)) % (1 << W);
                if (m_cnt[k] < W) m_cnt[k] = m_cnt[k] + 1;
                reached = (m_cnt[k] == W);
            end
            if (k == 2 && reached) begin
                m_store[k] = m_sr[k]; m_cnt[k] = 0;
            end else if (la) begin
                m_store[k] = pre; m_cnt[k] = 0;
            end
        end
    endtask

    // Apply controls for one edge, update the model, sample 1 ns after the edge.
    task automatic step(input logic sh, input logic b, input logic la, input logic cl);
        shift_en = sh; ser_in = b; latch_en = la; nsclr = cl;
        model_edge(sh, b, la, cl);
        @(posedge clk);
        #1;
        shift_en = 1'b0; latch_en = 1'b0; nsclr = 1'b1;
    endtask

    task automatic test_reset();
        nrst = 1'b0; noe = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        total++; if (q0 !== 8'hFF) begin bad++; $display("FAIL reset_hiz q=%h exp=%h", q0, 8'hFF); end
        total++; if (so0 !== 1'b0) begin bad++; $display("FAIL reset_ser_out got=%b exp=0", so0); end
        total++; if (wr0 !== 1'b0) begin bad++; $display("FAIL reset_word_rdy got=%b exp=0", wr0); end
        noe = 1'b0;
        #1;
        total++; if (q0 !== 8'h00) begin bad++; $display("FAIL reset_q_plain got=%h exp=00", q0); end
        total++; if (q1 !== 8'hFF) begin bad++; $display("FAIL reset_q_inv got=%h exp=ff", q1); end
        total++; if (q2 !== 8'h00) begin bad++; $display("FAIL reset_q_auto got=%h exp=00", q2); end
        nrst = 1'b1;
        #1;
    endtask

    task automatic test_shift_latch();
        logic [W-1:0] pat;
        pat = 8'hA5;
        for (int i = W - 1; i >= 0; i--) step(1'b1, pat[i], 1'b0, 1'b1);
        total++; if (wr0 !== 1'b1) begin bad++; $display("FAIL sl_word_rdy got=%b exp=1", wr0); end
        total++; if (so0 !== 1'b1) begin bad++; $display("FAIL sl_ser_out got=%b exp=1", so0); end
        total++; if (q0 !== 8'h00) begin bad++; $display("FAIL sl_q_before_latch got=%h exp=00", q0); end
        total++; if (q2 !== 8'hA5) begin bad++; $display("FAIL sl_auto_q got=%h exp=a5", q2); end
        total++; if (wr2 !== 1'b0) begin bad++; $display("FAIL sl_auto_word_rdy got=%b exp=0", wr2); end
        step(1'b0, 1'b0, 1'b1, 1'b1);
        total++; if (q0 !== 8'hA5) begin bad++; $display("FAIL sl_q_plain got=%h exp=a5", q0); end
        total++; if (q1 !== 8'h5A) begin bad++; $display("FAIL sl_q_inv got=%h exp=5a", q1); end
        total++; if (wr0 !== 1'b0) begin bad++; $display("FAIL sl_word_rdy_after_latch got=%b exp=0", wr0); end
    endtask

    task automatic test_simul_shift_latch();
        logic [W-1:0] pat;
        pat = 8'h0F;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = W - 1; i >= 0; i--) step(1'b1, pat[i], 1'b0, 1'b1);
        total++; if (q2 !== 8'h0F) begin bad++; $display("FAIL ssl_auto_q got=%h exp=0f", q2); end
        step(1'b1, 1'b1, 1'b1, 1'b1);
        total++; if (q0 !== 8'h0F) begin bad++; $display("FAIL ssl_store got=%h exp=0f", q0); end
        total++; if (q1 !== 8'hF0) begin bad++; $display("FAIL ssl_store_inv got=%h exp=f0", q1); end
        total++; if (wr0 !== 1'b0) begin bad++; $display("FAIL ssl_word_rdy got=%b exp=0", wr0); end
        step(1'b0, 1'b0, 1'b1, 1'b1);
        total++; if (q0 !== 8'h1F) begin bad++; $display("FAIL ssl_sr_after got=%h exp=1f", q0); end
    endtask

    task automatic test_nsclr_priority();
        for (int i = 0; i < W; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
        total++; if (wr0 !== 1'b1) begin bad++; $display("FAIL clr_word_rdy_pre got=%b exp=1", wr0); end
        total++; if (q2 !== 8'hFF) begin bad++; $display("FAIL clr_auto_q got=%h exp=ff", q2); end
        step(1'b1, 1'b1, 1'b0, 1'b0);
        total++; if (wr0 !== 1'b0) begin bad++; $display("FAIL clr_word_rdy got=%b exp=0", wr0); end
        total++; if (so0 !== 1'b0) begin bad++; $display("FAIL clr_ser_out got=%b exp=0", so0); end
        total++; if (q0 !== 8'h1F) begin bad++; $display("FAIL clr_q_unchanged got=%h exp=1f", q0); end
        step(1'b0, 1'b0, 1'b1, 1'b1);
        total++; if (q0 !== 8'h00) begin bad++; $display("FAIL clr_sr_zero got=%h exp=00", q0); end
    endtask

    task automatic test_auto_latch();
        logic [W-1:0] pat;
        logic [3:0]   extra;
        pat = 8'h3C; extra = 4'hA;
        for (int i = W - 1; i >= 1; i--) step(1'b1, pat[i], 1'b0, 1'b1);
        total++; if (q2 !== 8'h00) begin bad++; $display("FAIL auto_q_early got=%h exp=00", q2); end
        step(1'b1, pat[0], 1'b0, 1'b1);
        total++; if (q2 !== 8'h3C) begin bad++; $display("FAIL auto_q got=%h exp=3c", q2); end
        total++; if (wr2 !== 1'b0) begin bad++; $display("FAIL auto_word_rdy got=%b exp=0", wr2); end
        for (int i = 3; i >= 0; i--) begin
            step(1'b1, extra[i], 1'b0, 1'b1);
            total++; if (q2 !== 8'h3C || wr2 !== 1'b0) begin
                bad++; $display("FAIL auto_hold q=%h rdy=%b exp=3c/0", q2, wr2);
            end
        end
        total++; if (wr0 !== 1'b1) begin bad++; $display("FAIL auto_plain_rdy got=%b exp=1", wr0); end
    endtask

    task automatic test_async_reset();
        logic [W-1:0] pat;
        pat = 8'h96;
        for (int i = 0; i < 5; i++) step(1'b1, 1'($urandom % 2), 1'b0, 1'b1);
        nrst = 1'b0;
        #1;
        total++; if (q0 !== 8'h00) begin bad++; $display("FAIL arst_q_plain got=%h exp=00", q0); end
        total++; if (q1 !== 8'hFF) begin bad++; $display("FAIL arst_q_inv got=%h exp=ff", q1); end
        total++; if (so0 !== 1'b0 || wr0 !== 1'b0) begin
            bad++; $display("FAIL arst_flags so=%b rdy=%b exp=0/0", so0, wr0);
        end
        nrst = 1'b1;
        model_reset();
        #1;
        for (int i = W - 1; i >= 0; i--) step(1'b1, pat[i], 1'b0, 1'b1);
        total++; if (wr0 !== 1'b1) begin bad++; $display("FAIL arst_word_rdy got=%b exp=1", wr0); end
        total++; if (q2 !== 8'h96) begin bad++; $display("FAIL arst_auto_q got=%h exp=96", q2); end
        step(1'b0, 1'b0, 1'b1, 1'b1);
        total++; if (q0 !== 8'h96) begin bad++; $display("FAIL arst_q_new got=%h exp=96", q0); end
        total++; if (q1 !== 8'h69) begin bad++; $display("FAIL arst_q_new_inv got=%h exp=69", q1); end
    endtask

    task automatic test_random();
        logic sh, b, la, cl;
        for (int n = 0; n < 400; n++) begin
            sh  = 1'($urandom % 2);
            b   = 1'($urandom % 2);
            la  = ($urandom % 6) == 0;
            cl  = ($urandom % 10) != 0;
            noe = ($urandom % 4) == 0;
            step(sh, b, la, cl);
            for (int k = 0; k < 3; k++) begin
                total++;
                if (q_of(k) !== exp_q(k) || so_of(k) !== exp_so(k) || wr_of(k) !== exp_wr(k)) begin
                    bad++;
                    $display("FAIL rand n=%0d inst=%0d q=%h/%h so=%b/%b rdy=%b/%b (got/exp)",
                             n, k, q_of(k), exp_q(k), so_of(k), exp_so(k), wr_of(k), exp_wr(k));
                end
            end
        end
        noe = 1'b0;
    endtask

    initial begin
        test_reset();
        test_shift_latch();
        test_simul_shift_latch();
        test_nsclr_priority();
        test_auto_latch();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
